fc_seq_ctrl: RTL and testbench
==============================

FC_SEQ_CTRL -- requirements
Module: fc_seq_ctrl

Interface
REQ-001 Parameter N_IN, default 4: inputs per neuron.
REQ-002 Parameter N_OUT, default 2: neurons per layer.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_vec holds a valid feature vector.
REQ-006 in_ready  output  1  block can accept a vector (IDLE only).
REQ-007 in_vec  input  N_IN x 16 signed  flattened pooled features.
REQ-008 abort  input  1  synchronous cancel of the current job.
REQ-009 w_rd_en  output  1  weight ROM read strobe.
REQ-010 w_addr  output  max(1,clog2(N_IN*N_OUT))  weight index = neuron*N_IN + i.
REQ-011 w_data  input  8 signed  weight; valid one cycle after w_rd_en.
REQ-012 b_addr  output  max(1,clog2(N_OUT))  bias index = current neuron.
REQ-013 b_data  input  16 signed  bias; valid one cycle after b_addr changes.
REQ-014 out_valid  output  1  out_vec holds a complete result.
REQ-015 out_ready  input  1  consumer accepts out_vec.
REQ-016 out_vec  output  N_OUT x 16 signed  neuron results.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, MAC, FIN, DONE.
REQ-019 IDLE: in_ready=1; in_valid&in_ready at an edge SHALL capture in_vec into an internal register, clear neuron/input counters and the accumulator, and go to MAC.
REQ-020 MAC: lasts N_IN cycles; per cycle, w_rd_en=1 and w_addr=neuron*N_IN+i, i counting 0..N_IN-1; the product for address k SHALL accumulate one cycle later.
REQ-021 FIN: one cycle; accumulate the last product, add sign-extended b_data, saturate, write out_vec[neuron]; if neuron<N_OUT-1, increment neuron, clear i and accumulator, go to MAC; else go to DONE.
REQ-022 Arithmetic: 16x8 signed product, sign-extended into a 32-bit signed accumulator; final value saturated to [-32768, 32767].
REQ-023 out_valid SHALL rise exactly N_OUT*(N_IN+1) cycles after the accepting edge (10 for defaults).
REQ-024 DONE: out_valid=1; out_vec stable until an edge with out_ready=1, which returns to IDLE; no input accepted in the same cycle.
REQ-025 out_vec entries not yet written in the current job SHALL keep their previous values; out_vec changes only in FIN.
REQ-026 abort=1 in any state SHALL force IDLE at the next edge, deassert out_valid, and discard partial results; abort and in_valid together in IDLE: abort wins, no capture.
REQ-027 w_rd_en SHALL be 0 outside MAC; w_addr SHALL never exceed N_IN*N_OUT-1.
REQ-028 in_vec changes after capture SHALL have no effect on the job in progress.

Reset
REQ-029 reset SHALL asynchronously force IDLE, counters=0, accumulator=0, out_vec=0, out_valid=0, w_rd_en=0, busy=0, w_addr=0, b_addr=0.
REQ-030 Reset asserted mid-job SHALL abandon the job; after release in_ready=1 on the first cycle.

Structure
REQ-031 Shared package fc_pkg SHALL hold DATA_W=16, WEIGHT_W=8, ACC_W=32, the FSM state enum, and the saturate-to-16 function.
REQ-032 Sub-module fc_mac_unit SHALL contain the multiply, accumulator, bias add and saturation; fc_seq_ctrl holds the FSM, counters, address generation and handshakes.

Verification (ROM: neuron0 w=[2,-1,3,1] b=0; neuron1 w=[-2,2,1,-3] b=5)
REQ-033 in_vec=[1,2,3,4], out_ready=1 -> out_vec=[13,-2], out_valid exactly 10 cycles after accept, held 1 cycle.
REQ-034 in_vec=[32767,0,32767,32767] -> out_vec=[32767,-32768] (saturated both ways).
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid and out_vec=[13,-2] stable, in_ready=0; returns to IDLE the edge after out_ready=1.
REQ-036 reset pulse 4 cycles after accept -> out_valid=0, out_vec=[0,0], in_ready=1 after release; next vector [1,2,3,4] yields [13,-2].
REQ-037 abort 6 cycles after accept, then in_vec=[1,1,1,1] -> no output from the aborted job; output [5,3] after 10 cycles.
REQ-038 in_vec changed to [9,9,9,9] one cycle after accepting [1,2,3,4] -> result still [13,-2].

Source files
------------

// File: rtl/fc_pkg.sv
// Shared widths, FSM encoding and the saturation helper for the fully-connected
// layer sequencer.
package fc_pkg;

    localparam int DATA_W   = 16;
    localparam int WEIGHT_W = 8;
    localparam int ACC_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_FIN,
        ST_DONE
    } state_t;

    // Clamp a wide accumulator value into the signed DATA_W output range.
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if ((&v[ACC_W-1:DATA_W-1]) || !(|v[ACC_W-1:DATA_W-1]))
            return v[DATA_W-1:0];
        return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Multiply-accumulate datapath: 16x8 signed product into a 32-bit accumulator,
// plus the bias add and saturation that produce one neuron result.
module fc_mac_unit
    import fc_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_i,
    input  logic                       acc_en_i,
    input  logic signed [DATA_W-1:0]   feat_i,
    input  logic signed [WEIGHT_W-1:0] w_i,
    input  logic signed [DATA_W-1:0]   bias_i,
    output logic signed [DATA_W-1:0]   result_o
);

    localparam int PROD_W = DATA_W + WEIGHT_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum;

    assign prod     = PROD_W'(feat_i) * PROD_W'(w_i);
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(bias_i);
    assign acc_d    = acc_en_i ? acc_q + prod_ext : acc_q;

    // The result sees the product arriving this cycle, so the last tap needs no extra cycle.
    assign sum      = acc_d + bias_ext;
    assign result_o = sat16(sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_q <= '0;
        else if (clr_i)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: captures a feature vector, walks the weight
// ROM neuron by neuron and presents the saturated results with a handshake.
module fc_seq_ctrl
    import fc_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int N_OUT = 2,
    localparam int AW    = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN*DATA_W-1:0]      in_vec,
    input  logic                        abort,
    output logic                        w_rd_en,
    output logic [AW-1:0]               w_addr,
    input  logic signed [WEIGHT_W-1:0]  w_data,
    output logic [NW-1:0]               b_addr,
    input  logic signed [DATA_W-1:0]    b_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_OUT*DATA_W-1:0]     out_vec,
    output logic                        busy
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

    state_t                   state_q;
    logic [IW-1:0]            i_q;
    logic [IW-1:0]            sel_q;
    logic [NW-1:0]            n_q;
    logic                     vld_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] vec_q [N_IN];
    logic signed [DATA_W-1:0] out_q [N_OUT];
    logic signed [DATA_W-1:0] feat;
    logic signed [DATA_W-1:0] mac_result;
    logic                     accept;

    assign accept    = (state_q == ST_IDLE) && in_valid && !abort;
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign w_rd_en   = (state_q == ST_MAC);
    assign w_addr    = AW'(n_q) * AW'(N_IN) + AW'(i_q);
    assign b_addr    = n_q;
    assign out_valid = out_valid_q;

    // w_data lags the address by one cycle, so the feature index is delayed to match.
    assign feat = vec_q[sel_q];

    fc_mac_unit u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q != ST_MAC),
        .acc_en_i (vld_q),
        .feat_i   (feat),
        .w_i      (w_data),
        .bias_i   (b_data),
        .result_o (mac_result)
    );

    always_ff @(posedge clk) begin
        if (accept)
            for (int j = 0; j < N_IN; j++)
                vec_q[j] <= in_vec[j*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            sel_q       <= '0;
            n_q         <= '0;
            vld_q       <= 1'b0;
            out_valid_q <= 1'b0;
            for (int j = 0; j < N_OUT; j++)
                out_q[j] <= '0;
        end else begin
            vld_q <= (state_q == ST_MAC);
            sel_q <= i_q;
            if (abort) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                i_q         <= '0;
                n_q         <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (in_valid) begin
                            i_q     <= '0;
                            n_q     <= '0;
                            state_q <= ST_MAC;
                        end
                    end
                    ST_MAC: begin
                        if (i_q == I_LAST)
                            state_q <= ST_FIN;
                        else
                            i_q <= i_q + 1'b1;
                    end
                    ST_FIN: begin
                        out_q[n_q] <= mac_result;
                        if (n_q == N_LAST) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            n_q     <= n_q + 1'b1;
                            i_q     <= '0;
                            state_q <= ST_MAC;
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            i_q         <= '0;
                            n_q         <= '0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign out_vec[j*DATA_W +: DATA_W] = out_q[j];
    end

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Directed bench for fc_seq_ctrl with a small registered weight/bias ROM.
module tb_fc_seq_ctrl;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [63:0]        in_vec;
    logic               abort;
    logic               w_rd_en;
    logic [2:0]         w_addr;
    logic signed [7:0]  w_data;
    logic [0:0]         b_addr;
    logic signed [15:0] b_data;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_vec;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [7:0]  wrom [8] = '{8'sd2, -8'sd1, 8'sd3, 8'sd1, -8'sd2, 8'sd2, 8'sd1, -8'sd3};
    logic signed [15:0] brom [2] = '{16'sd0, 16'sd5};

    fc_seq_ctrl #(.N_IN(4), .N_OUT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .abort     (abort),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_data <= wrom[w_addr];
        b_data <= brom[b_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic signed [15:0] ov(input int j);
        return out_vec[j*16 +: 16];
    endfunction

    // Accept v, follow the ROM address stream, and stop on the cycle out_valid is seen.
    task automatic run_job(input string tag, input logic [63:0] v, input bit chg,
                           input int e0, input int e1);
        int cnt;
        bit exp_en;
        in_vec   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (chg) in_vec = pack4(9, 9, 9, 9);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            exp_en = (cnt < 10) && (cnt % 5 != 4);
            chk({tag, "_rd_en"}, w_rd_en, exp_en);
            if (exp_en) chk({tag, "_addr"}, w_addr, (cnt / 5) * 4 + cnt % 5);
            step();
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 10);
        chk({tag, "_out0"}, ov(0), e0);
        chk({tag, "_out1"}, ov(1), e1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", w_rd_en, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_out_vec", out_vec, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        step();
        chk("idle_in_ready", in_ready, 1);

        run_job("basic", pack4(1, 2, 3, 4), 1'b0, 13, -2);
        step();
        chk("basic_held1", out_valid, 0);
        chk("basic_back_idle", in_ready, 1);

        run_job("sat", pack4(32767, 0, 32767, 32767), 1'b0, 32767, -32768);
        step();
        chk("sat_back_idle", in_ready, 1);

        out_ready = 1'b0;
        run_job("bp", pack4(1, 2, 3, 4), 1'b0, 13, -2);
        in_vec   = pack4(1, 1, 1, 1);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_out0", ov(0), 13);
            chk("bp_out1", ov(1), -2);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_no_capture", busy, 0);
        chk("bp_release_ready", in_ready, 1);

        in_vec   = pack4(1, 2, 3, 4);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out_vec", out_vec, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_en", w_rd_en, 0);
        step();
        reset = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        run_job("after_rst", pack4(1, 2, 3, 4), 1'b0, 13, -2);
        step();

        in_vec   = pack4(1, 2, 3, 4);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        abort = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        in_vec   = pack4(1, 1, 1, 1);
        in_valid = 1'b1;
        step();
        chk("abort_wins", busy, 0);
        abort    = 1'b0;
        in_valid = 1'b0;
        run_job("post_abort", pack4(1, 1, 1, 1), 1'b0, 5, 3);
        step();

        run_job("vec_change", pack4(1, 2, 3, 4), 1'b1, 13, -2);
        step();
        chk("vec_change_idle", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
